// File: rtl/useq_host_pkg.sv
// rtl/useq_host_pkg.sv - shared types and widths for the useq host bridge
package useq_host_pkg;
  localparam int BYTE_W      = 8;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SETTLE,
    RX_HOLD
  } rx_state_t;
endpackage

// File: rtl/useq_host_txq.sv
// rtl/useq_host_txq.sv - circular host-to-useq byte queue with registered enq_ready
module useq_host_txq
  import useq_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] enq_data,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic              deq,
  output logic [BYTE_W-1:0] head,
  output logic              empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic              do_enq, do_deq;

  assign empty  = (count == '0);
  assign do_enq = enq_valid & enq_ready;
  assign do_deq = deq & ~empty;
  assign head   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_enq && !do_deq)      count_nxt = count + 1'b1;
    else if (!do_enq && do_deq) count_nxt = count - 1'b1;
  end

  // enq_ready is registered from the next count, so a full queue refuses the
  // enqueue even when a dequeue happens in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enq_ready <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(do_enq);
      rd_ptr    <= rd_ptr + PTR_W'(do_deq);
      count     <= count_nxt;
      enq_ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end
endmodule

// File: rtl/useq_host_bridge.sv
// rtl/useq_host_bridge.sv - host endpoint of the useq FIFO interface (valid/ready byte streams)
// Optional USEQ_HOST_STATS_EN adds tx_cnt/rx_cnt byte counters.
module useq_host_bridge
  import useq_host_pkg::*;
#(
  parameter int TX_DEPTH    = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              write_fifo,
  output logic [BYTE_W-1:0] fifo_in,
  input  logic              fifo_full,
  output logic              read_fifo,
  input  logic [BYTE_W-1:0] fifo_out,
  input  logic              fifo_empty,
  output logic              stall,
  input  logic              stall_clr
`ifdef USEQ_HOST_STATS_EN
  , output logic [15:0]     tx_cnt
  , output logic [15:0]     rx_cnt
`endif
);
  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);

  logic [BYTE_W-1:0]      txq_head;
  logic                   txq_empty, push_go, blocked;
  logic [STALL_CNT_W-1:0] stall_cnt;

  useq_host_txq #(.DEPTH(TX_DEPTH)) u_txq (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_data  (s_data),
    .enq_valid (s_valid),
    .enq_ready (s_ready),
    .deq       (push_go),
    .head      (txq_head),
    .empty     (txq_empty)
  );

  // Gating on write_fifo leaves an idle cycle after every push so fifo_full can catch up.
  assign push_go = ~txq_empty & ~fifo_full & ~write_fifo;
  assign blocked = ~txq_empty & fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_fifo <= 1'b0;
      fifo_in    <= '0;
    end else begin
      write_fifo <= push_go;
      if (push_go) fifo_in <= txq_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (push_go) begin
      stall_cnt <= '0;
    end else if (blocked && stall_cnt != LIMIT) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt + 1'b1 == LIMIT) stall <= 1'b1;
    end
  end

  rx_state_t         state, state_nxt;
  logic [BYTE_W-1:0] m_data_nxt;
  logic              m_valid_nxt, read_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      m_data    <= '0;
      m_valid   <= 1'b0;
      read_fifo <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_data    <= m_data_nxt;
      m_valid   <= m_valid_nxt;
      read_fifo <= read_nxt;
    end
  end

  // The byte is captured from the show-ahead head before the pop strobe goes out.
  always_comb begin
    state_nxt   = state;
    m_data_nxt  = m_data;
    m_valid_nxt = m_valid;
    read_nxt    = 1'b0;
    case (state)
      RX_IDLE: begin
        m_valid_nxt = 1'b0;
        if (!fifo_empty) begin
          m_data_nxt = fifo_out;
          read_nxt   = 1'b1;
          state_nxt  = RX_SETTLE;
        end
      end
      RX_SETTLE: begin
        m_valid_nxt = 1'b1;
        state_nxt   = RX_HOLD;
      end
      RX_HOLD: begin
        if (m_ready) begin
          m_valid_nxt = 1'b0;
          state_nxt   = RX_IDLE;
        end
      end
      default: begin
        m_valid_nxt = 1'b0;
        state_nxt   = RX_IDLE;
      end
    endcase
  end

`ifdef USEQ_HOST_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      tx_cnt <= tx_cnt + 16'(push_go);
      rx_cnt <= rx_cnt + 16'(read_nxt);
    end
  end
`endif
endmodule
